ue14500_sequencer: RTL and testbench
====================================

// Module: ue14500_sequencer
// PURPOSE
//  Program sequencer for the UE14500 1-bit core (MC14500-style ISA). Owns the program counter,
//  fetches 8-bit words from external program memory over a req/ack handshake and issues one
//  execute strobe per instruction to the core.
//  Handles control-flow opcodes locally: JMP, RTN, SKZ, NOPF, NOPO. Supports run/halt/single-step.
// PARAMETERS
//  AW        8      program address width; 1 <= AW <= 8
//  RESET_PC  0      PC value loaded on reset (AW bits)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  run        in   1   level; 1 = free-run fetch/execute
//  step       in   1   one-cycle pulse; executes exactly one instruction when halted
//  halted     out  1   1 while in HALT
//  pc         out  AW  current program counter (debug)
//  mem_req    out  1   fetch request; held until mem_ack
//  mem_addr   out  AW  fetch address (= pc while mem_req=1, else 0)
//  mem_ack    in   1   word valid on mem_data this cycle
//  mem_data   in   8   program word: [7:4] opcode, [3:0] I/O address
//  core_en    out  1   one-cycle execute strobe to core
//  core_instr out  4   opcode to core, valid with core_en
//  core_addr  out  4   I/O address to core, valid with core_en
//  core_rr    in   1   core result register, sampled in EXEC
//  flg0       out  1   one-cycle pulse on NOPO (opcode 0x0)
//  flgf       out  1   one-cycle pulse on NOPF (opcode 0xF)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=HALT, pc=RESET_PC, ir=0, all outputs 0 except halted=1.
//   Reset mid-fetch drops mem_req immediately; pending ack is discarded.
//  States: HALT, FETCH, TGT, EXEC.
//  HALT:  halted=1. run=1 -> FETCH (step ignored). run=0 & step=1 -> FETCH, set step_mode.
//  FETCH: mem_req=1, mem_addr=pc. On mem_ack: ir<=mem_data, pc<=pc+1.
//         opcode 0xC (JMP) -> TGT; any other opcode -> EXEC. No ack -> stay.
//  TGT:   mem_req=1, mem_addr=pc. On mem_ack: pc<=mem_data[AW-1:0] (two-word JMP);
//         then -> FETCH if run=1 & !step_mode, else HALT. JMP never asserts core_en.
//  EXEC:  core_en=1 for exactly this cycle, core_instr=ir[7:4], core_addr=ir[3:0].
//   0xD RTN: pc<=pc+1 (skip next word unconditionally).
//   0xE SKZ: if core_rr==0 pc<=pc+1, else no change.
//   0xF NOPF: flgf=1 this cycle; next state HALT regardless of run.
//   0x0 NOPO: flg0=1 this cycle.
//   Next state otherwise: FETCH if run=1 & !step_mode, else HALT. step_mode clears on entering HALT.
//  Latency (zero-wait memory, ack same cycle as req): non-JMP = 2 cycles, JMP = 2 cycles.
//  pc arithmetic modulo 2^AW: 2^AW-1 + 1 wraps to 0; skips and fetch increments wrap identically.
//  run falling mid-instruction: current instruction (incl. JMP target) completes, then HALT.
//  mem_ack outside FETCH/TGT ignored. core_en, flg0, flgf never assert outside EXEC.
//  A skip advances one word only; skipping a JMP lands on its target word (software rule).
// STRUCTURE
//  Shared header ue14500_defs.vh: opcode constants (OP_NOPO=4'h0, OP_JMP=4'hC, OP_RTN=4'hD,
//   OP_SKZ=4'hE, OP_NOPF=4'hF) and state encodings; also used by core and benches.
//  Single flat module; FSM + pc register + ir register. No sub-module required.
// TESTING
//  1 Reset, run=1, mem = {0x10,0x21,0xF0}, zero-wait ack -> core_en x3 with instr 1,2,F;
//    flgf pulse at third EXEC; halted=1, pc=3.
//  2 mem[0]=0xC0, mem[1]=0x40, mem[0x40]=0xF0 -> no core_en for JMP; next mem_addr=0x40; halt pc=0x41.
//  3 SKZ: mem {0xE0,0x30,0xF0}; core_rr=0 -> 0x30 never executed, halt pc=3;
//    repeat with core_rr=1 -> 0x30 executed (core_en x3).
//  4 Wrap: RESET_PC=8'hFF, mem[FF]=0x00, mem[00]=0xF0 -> flg0 pulse, then fetch addr 0x00, halt pc=1.
//  5 Step: run=0, one step pulse -> exactly one core_en, halted returns 1; run=1 & step same cycle
//    -> free run.
//  6 Memory ack delayed 3 cycles, rst_n=0 during wait -> mem_req drops at once, pc=RESET_PC, halted=1.

Source files
------------

// File: rtl/ue14500_sequencer_pkg.sv
// Shared opcode constants and sequencer state encoding for the UE14500 core family.
package ue14500_sequencer_pkg;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_TGT   = 2'd2,
    ST_EXEC  = 2'd3
  } state_e;

endpackage

// File: rtl/ue14500_sequencer.sv
// Program sequencer: owns the PC, fetches words over req/ack and strobes the core once per instruction.
// Two cycles per instruction with zero-wait memory; fetch waits indefinitely for mem_ack.
module ue14500_sequencer
  import ue14500_sequencer_pkg::*;
#(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          step,
  output logic          halted,
  output logic [AW-1:0] pc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_data,
  output logic          core_en,
  output logic [3:0]    core_instr,
  output logic [3:0]    core_addr,
  input  logic          core_rr,
  output logic          flg0,
  output logic          flgf
);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    ir_q, ir_d;
  logic          step_mode_q, step_mode_d;
  logic [AW-1:0] pc_inc;
  logic          cont;

  assign pc_inc = pc_q + AW'(1);
  // Free-running only while run is held and we did not enter via a single step.
  assign cont   = run & ~step_mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HALT;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      step_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      step_mode_q <= step_mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    step_mode_d = step_mode_q;
    mem_req     = 1'b0;
    core_en     = 1'b0;
    flg0        = 1'b0;
    flgf        = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (run) begin
          state_d     = ST_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = ST_FETCH;
          step_mode_d = 1'b1;
        end
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_data;
          pc_d    = pc_inc;
          state_d = (mem_data[7:4] == OP_JMP) ? ST_TGT : ST_EXEC;
        end
      end
      ST_TGT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_d    = mem_data[AW-1:0];
          state_d = cont ? ST_FETCH : ST_HALT;
        end
      end
      default: begin
        core_en = 1'b1;
        case (ir_q[7:4])
          OP_RTN:  pc_d = pc_inc;
          OP_SKZ:  if (!core_rr) pc_d = pc_inc;
          OP_NOPF: flgf = 1'b1;
          OP_NOPO: flg0 = 1'b1;
          default: ;
        endcase
        state_d = (cont && ir_q[7:4] != OP_NOPF) ? ST_FETCH : ST_HALT;
      end
    endcase
    if (state_d == ST_HALT) step_mode_d = 1'b0;
  end

  assign halted     = (state_q == ST_HALT);
  assign pc         = pc_q;
  assign mem_addr   = mem_req ? pc_q : '0;
  assign core_instr = core_en ? ir_q[7:4] : 4'h0;
  assign core_addr  = core_en ? ir_q[3:0] : 4'h0;

endmodule

// File: tb/tb_ue14500_sequencer.sv
// Scoreboard bench: stimulus queues expected fetches/executes, a negedge monitor pops and compares.
module tb_ue14500_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       halted;
  logic [7:0] pc;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic       core_en;
  logic [3:0] core_instr;
  logic [3:0] core_addr;
  logic       core_rr = 1'b0;
  logic       flg0;
  logic       flgf;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  int         ack_delay = 0;
  int         wait_cnt = 0;

  typedef struct {
    logic [3:0] instr;
    logic [3:0] addr;
    logic       f0;
    logic       ff;
  } ex_t;

  ex_t        exq[$];
  logic [7:0] fq[$];

  ue14500_sequencer #(.AW(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halted(halted), .pc(pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .core_en(core_en), .core_instr(core_instr), .core_addr(core_addr), .core_rr(core_rr),
    .flg0(flg0), .flgf(flgf)
  );

  always #5 clk = ~clk;

  // Memory responder: ack after ack_delay cycles of pending request.
  assign mem_ack  = mem_req && (wait_cnt >= ack_delay);
  assign mem_data = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ex(input logic [7:0] w);
    ex_t e;
    e.instr = w[7:4];
    e.addr  = w[3:0];
    e.f0    = (w[7:4] == 4'h0);
    e.ff    = (w[7:4] == 4'hF);
    exq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_en) begin
        if (exq.size() == 0) chk("exec_unexpected", {core_instr, core_addr}, 32'hFFFF);
        else begin
          ex_t e;
          e = exq.pop_front();
          chk("core_instr", core_instr, e.instr);
          chk("core_addr", core_addr, e.addr);
          chk("flg0", flg0, e.f0);
          chk("flgf", flgf, e.ff);
        end
      end else if (flg0 || flgf) begin
        chk("flag_outside_exec", {flg0, flgf}, 0);
      end
      if (mem_req && mem_ack) begin
        if (fq.size() == 0) chk("fetch_unexpected", mem_addr, 32'hFFFF);
        else chk("mem_addr", mem_addr, fq.pop_front());
      end
    end
  end

  task automatic do_reset();
    run   = 1'b0;
    step  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h10;
  endtask

  // Free-run until NOPF, dropping run as the flgf pulse is seen so the sequencer stays halted.
  task automatic run_prog(input int budget);
    bit done = 1'b0;
    run = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      step = 1'b0;
      if (flgf) begin
        run  = 1'b0;
        done = 1'b1;
      end
    end
    run = 1'b0;
    if (!done) chk("run_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic step_once(input int budget);
    bit done = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (halted) done = 1'b1;
    end
    if (!done) chk("step_timeout", 0, 1);
  endtask

  task automatic chk_end(input string name, input logic [7:0] exp_pc);
    chk({name, "_halted"}, halted, 1);
    chk({name, "_pc"}, pc, exp_pc);
    chk({name, "_exq_left"}, exq.size(), 0);
    chk({name, "_fq_left"}, fq.size(), 0);
  endtask

  initial begin
    clear_mem();
    do_reset();
    chk("rst_halted", halted, 1);
    chk("rst_pc", pc, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_core_en", core_en, 0);

    // Straight-line run ending in NOPF
    mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'hF0;
    fq = '{8'h00, 8'h01, 8'h02};
    push_ex(8'h10); push_ex(8'h21); push_ex(8'hF0);
    run_prog(50);
    chk_end("seq", 8'h03);

    // Two-word JMP never strobes the core
    clear_mem();
    do_reset();
    mem[0] = 8'hC0; mem[1] = 8'h40; mem[8'h40] = 8'hF0;
    fq = '{8'h00, 8'h01, 8'h40};
    push_ex(8'hF0);
    run_prog(50);
    chk_end("jmp", 8'h41);

    // SKZ with rr=0 skips the following word
    clear_mem();
    do_reset();
    core_rr = 1'b0;
    mem[0] = 8'hE0; mem[1] = 8'h30; mem[2] = 8'hF0;
    fq = '{8'h00, 8'h02};
    push_ex(8'hE0); push_ex(8'hF0);
    run_prog(50);
    chk_end("skz0", 8'h03);

    // SKZ with rr=1 falls through
    do_reset();
    core_rr = 1'b1;
    fq = '{8'h00, 8'h01, 8'h02};
    push_ex(8'hE0); push_ex(8'h30); push_ex(8'hF0);
    run_prog(50);
    chk_end("skz1", 8'h03);
    core_rr = 1'b0;

    // RTN skips unconditionally
    clear_mem();
    do_reset();
    mem[0] = 8'hD0; mem[1] = 8'h55; mem[2] = 8'hF3;
    fq = '{8'h00, 8'h02};
    push_ex(8'hD0); push_ex(8'hF3);
    run_prog(50);
    chk_end("rtn", 8'h03);

    // PC wrap: single-step a JMP to 0xFF, NOPO there, then fetch wraps to 0x00
    clear_mem();
    do_reset();
    mem[0] = 8'hC0; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    fq = '{8'h00, 8'h01};
    step_once(50);
    chk_end("wrap_jmp", 8'hFF);
    mem[0] = 8'hF0;
    fq = '{8'hFF};
    push_ex(8'h00);
    step_once(50);
    chk_end("wrap_nopo", 8'h00);
    fq = '{8'h00};
    push_ex(8'hF0);
    step_once(50);
    chk_end("wrap_nopf", 8'h01);

    // Single step executes one instruction; run+step together free-runs
    clear_mem();
    do_reset();
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'hF0;
    fq = '{8'h00};
    push_ex(8'h12);
    step_once(50);
    chk_end("step1", 8'h01);
    repeat (3) @(negedge clk);
    chk("step_stays_halted", halted, 1);
    fq = '{8'h01, 8'h02};
    push_ex(8'h34); push_ex(8'hF0);
    step = 1'b1;
    run_prog(50);
    chk_end("runstep", 8'h03);

    // Reset during a waited fetch drops the request at once
    clear_mem();
    ack_delay = 3;
    do_reset();
    run = 1'b1;
    repeat (2) @(negedge clk);
    chk("wait_mem_req", mem_req, 1);
    chk("wait_mem_ack", mem_ack, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_halted", halted, 1);
    chk("arst_pc", pc, 0);
    run = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_end("post_arst", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
